// File: rtl/crp16_writeback_arbiter_pkg.sv
// Shared CRP16 writeback definitions (register file geometry, grant encoding).
// Mirrors the constants of crp16_defs.vh so RTL can import them as a package.
package crp16_writeback_arbiter_pkg;

  localparam int CRP16_REG_IDX_W = 4;
  localparam int CRP16_WORD_W    = 16;
  localparam logic [CRP16_REG_IDX_W-1:0] CRP16_REG_ZERO = 4'd0;
  localparam int STARVE_CNT_W    = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_MEM  = 2'd1,
    GNT_ALU  = 2'd2
  } wb_gnt_e;

  // r0 is hard-wired zero: accepted transfers to it never assert the write enable
  function automatic logic is_real_write(input logic [CRP16_REG_IDX_W-1:0] dest);
    return dest != CRP16_REG_ZERO;
  endfunction

endpackage

// File: rtl/crp16_writeback_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the ALU has waited behind MEM.
// Only instantiated when CRP16_WB_FAIRNESS_EN is defined.
module crp16_wb_starve_counter
  import crp16_writeback_arbiter_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = LIMIT[STARVE_CNT_W-1:0];

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (inc && (cnt != LIM))
      cnt <= cnt + 1'b1;
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/crp16_writeback_arbiter.sv
// Arbitrates the CRP16 register-file write port between MEM (priority) and ALU.
// Define CRP16_WB_FAIRNESS_EN to force-grant the ALU after STARVE_LIMIT losses.
module crp16_writeback_arbiter
  import crp16_writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [CRP16_REG_IDX_W-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [CRP16_REG_IDX_W-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       rf_write,
  output logic [CRP16_REG_IDX_W-1:0] rf_write_select,
  output logic [DATA_WIDTH-1:0]      rf_load_val
);

  logic    force_alu;
  wb_gnt_e gnt;

`ifdef CRP16_WB_FAIRNESS_EN
  logic at_limit;

  crp16_wb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (alu_valid && mem_valid && !force_alu),
    .clear    (alu_valid && alu_ready),
    .at_limit (at_limit)
  );

  assign force_alu = alu_valid && at_limit;
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_alu = 1'b0;
`endif

  // Readies never look at the producer's own valid; MEM wins unless the ALU is forced
  assign mem_ready = !reset && !force_alu;
  assign alu_ready = !reset && (!mem_valid || force_alu);

  always_comb begin
    gnt = GNT_NONE;
    if (mem_valid && mem_ready)
      gnt = GNT_MEM;
    else if (alu_valid && alu_ready)
      gnt = GNT_ALU;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write        <= 1'b0;
      rf_write_select <= '0;
      rf_load_val     <= '0;
    end else begin
      unique case (gnt)
        GNT_MEM: begin
          rf_write        <= is_real_write(mem_dest);
          rf_write_select <= mem_dest;
          rf_load_val     <= mem_data;
        end
        GNT_ALU: begin
          rf_write        <= is_real_write(alu_dest);
          rf_write_select <= alu_dest;
          rf_load_val     <= alu_data;
        end
        default: rf_write <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_crp16_writeback_arbiter.sv
// Directed + randomized bench for crp16_writeback_arbiter against a spec-level model.
module tb_crp16_writeback_arbiter;

  localparam int LIMIT = 3;
`ifdef CRP16_WB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_dest = '0, mem_dest = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        rf_write;
  logic [3:0]  rf_write_select;
  logic [15:0] rf_load_val;

  crp16_writeback_arbiter #(.DATA_WIDTH(16), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .rf_write(rf_write), .rf_write_select(rf_write_select), .rf_load_val(rf_load_val)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          waits = 0;
  logic        m_w = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [15:0] m_val = '0;
  logic [15:0] rf_obs [16];
  bit          obs_af, obs_mf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check readies against the model, advance, check the staged write.
  task automatic tick(input string tag);
    bit fz, ear, emr, af, mf;
    #1;
    fz  = FAIR && !reset && alu_valid && (waits == LIMIT);
    emr = !reset && !fz;
    ear = !reset && (!mem_valid || fz);
    chk({tag, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, emr});
    chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, ear});
    mf = mem_valid && emr;
    af = alu_valid && ear && !mf;
    obs_af = alu_valid && alu_ready;
    obs_mf = mem_valid && mem_ready;
    @(posedge clock);
    #1;
    if (reset) begin
      m_w = 1'b0; m_sel = '0; m_val = '0; waits = 0;
    end else begin
      if (mf) begin
        m_w = (mem_dest != 4'd0); m_sel = mem_dest; m_val = mem_data;
      end else if (af) begin
        m_w = (alu_dest != 4'd0); m_sel = alu_dest; m_val = alu_data;
      end else
        m_w = 1'b0;
      if (af) waits = 0;
      else if (alu_valid && mem_valid) waits = (waits < LIMIT) ? waits + 1 : LIMIT;
    end
    chk({tag, ".rf_write"}, {31'd0, rf_write}, {31'd0, m_w});
    chk({tag, ".rf_sel"}, {28'd0, rf_write_select}, {28'd0, m_sel});
    chk({tag, ".rf_val"}, {16'd0, rf_load_val}, {16'd0, m_val});
    if (rf_write) rf_obs[rf_write_select] = rf_load_val;
  endtask

  initial begin
    int first_alu, wcount;
    for (int i = 0; i < 16; i++) rf_obs[i] = '0;
    @(posedge clock);
    #1;

    // reset held two cycles with a load waiting
    mem_valid = 1'b1; mem_dest = 4'd3; mem_data = 16'h0333;
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    tick("post_rst");
    chk("post_rst.sel3", {28'd0, rf_write_select}, 32'd3);
    mem_valid = 1'b0;
    tick("idle");

    // simultaneous same destination: MEM then ALU
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 16'h2222;
    tick("same0");
    mem_valid = 1'b0;
    tick("same1");
    alu_valid = 1'b0;
    tick("same2");
    chk("r5_final", {16'd0, rf_obs[5]}, 32'h1111);

    // r0 writes are accepted but dropped
    mem_valid = 1'b1; mem_dest = 4'd0; mem_data = 16'hBEEF;
    tick("r0_mem");
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 16'hCAFE;
    tick("r0_alu");
    alu_valid = 1'b0;
    chk("r0_untouched", {16'd0, rf_obs[0]}, 32'h0);

    // starvation: loads every cycle for 8 cycles, ALU waiting throughout
    reset = 1'b1; tick("rst_starve"); reset = 1'b0;
    first_alu = 0;
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 16'h7777;
    mem_valid = 1'b1; mem_dest = 4'd8; mem_data = 16'h8000;
    for (int c = 1; c <= 8; c++) begin
      tick("starve");
      if (obs_af && first_alu == 0) first_alu = c;
      if (obs_af) begin alu_dest = 4'd9; alu_data = 16'($urandom); end
      if (obs_mf) begin mem_dest = 4'(8 + c % 4); mem_data = 16'($urandom); end
    end
    mem_valid = 1'b0;
    for (int c = 9; c <= 10; c++) begin
      tick("starve_tail");
      if (obs_af && first_alu == 0) first_alu = c;
      if (obs_af) alu_valid = 1'b0;
    end
    alu_valid = 1'b0;
    chk("starve_first_alu", first_alu, FAIR ? 32'd4 : 32'd9);

    // back-to-back alternating single producers
    wcount = 0;
    for (int i = 0; i < 10; i++) begin
      alu_valid = (i % 2 == 0); mem_valid = (i % 2 == 1);
      alu_dest = 4'(i + 1); mem_dest = 4'(i + 1);
      alu_data = 16'($urandom); mem_data = 16'($urandom);
      tick("b2b");
      if (rf_write) wcount++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("b2b_writes", wcount, 32'd10);

    // randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!alu_valid || obs_af) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_dest = 4'($urandom); alu_data = 16'($urandom);
      end
      if (!mem_valid || obs_mf) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_dest = 4'($urandom); mem_data = 16'($urandom);
      end
      tick("rand");
    end
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    tick("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crp16_writeback_arbiter.md
# crp16_writeback_arbiter

Shares the single write port of the CRP16 register file between the two writeback producers: the ALU result path and the memory-load return path. Each producer presents a destination register and value under a valid/ready handshake. The arbiter grants one producer per cycle and registers the winning write. Its registered outputs drive the register file's `write`, `write_select` and `load_val` inputs directly.

## Interface
- `DATA_WIDTH`, 16, width of the writeback value.
- `STARVE_LIMIT`, 3, consecutive ALU losses tolerated before the ALU is force-granted (only used with the fairness feature; range 1..7).
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU has a result to write.
- `alu_ready`  out  1  ALU result is accepted this cycle.
- `alu_dest`  in  4  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `mem_valid`  in  1  load data is available.
- `mem_ready`  out  1  load data is accepted this cycle.
- `mem_dest`  in  4  load destination register.
- `mem_data`  in  DATA_WIDTH  load data.
- `rf_write`  out  1  register file write enable, registered.
- `rf_write_select`  out  4  register file write index, registered.
- `rf_load_val`  out  DATA_WIDTH  register file write data, registered.

## Operation
- A transfer happens on a rising edge where `x_valid && x_ready`.
- Producers hold `x_dest`/`x_data` stable while valid and unaccepted. Producers never drop valid before acceptance.
- Ready outputs are combinational from both valids and the starvation state. At most one ready/valid pair fires per cycle.
- **Base priority is MEM over ALU**, because loads cannot be stalled in the memory stage:
  - `mem_ready = !reset && !force_alu`
  - `alu_ready = !reset && (!mem_valid || force_alu)`
  - `force_alu = alu_valid && (starve_cnt == STARVE_LIMIT)`, which is constant 0 without the fairness feature.
- With neither valid asserted, both readies are high. Ready does not depend on the producer's own valid.
- **Output stage**, on each edge:
  - Loads `rf_write_select`/`rf_load_val` from the accepted producer.
  - Sets `rf_write = 1`.
  - With no transfer, sets `rf_write = 0` and holds the select/value.
- **Register 0 is read-only.** A transfer with dest 4'd0 is accepted normally, but produces `rf_write = 0`.
- **Same dest on both producers in the same cycle:** the MEM write happens first and the ALU write the next cycle. The ALU value is final. This matches program order, because the ALU instruction is younger.
- **Starvation counter** (`starve_cnt`, 3 bits):
  - Increments, saturating at `STARVE_LIMIT`, when `alu_valid && mem_valid && !force_alu`.
  - Clears when the ALU transfers.
  - Holds otherwise.

## Timing
- Latency: a transfer on edge N gives `rf_write`/select/value valid during cycle N..N+1. The register file captures the value on edge N+1.
- Throughput: one write per cycle sustained. A back-to-back alternating stream never bubbles.
- Reset values:
  - `rf_write = 0`, `rf_write_select = 0`, `rf_load_val = 0`, `starve_cnt = 0`.
  - `alu_ready = mem_ready = 0` while `reset` is high.
- Reset mid-operation: a write staged in the output stage when reset is sampled is discarded. It never reaches the register file.
- Readies rise in the first cycle after reset deasserts.
- A producer asserting valid during reset is not accepted until that cycle.

## Configuration
- `CRP16_WB_FAIRNESS_EN` defined:
  - The starvation counter is compiled in.
  - After `STARVE_LIMIT` consecutive cycles in which the ALU waits behind MEM, the ALU is granted once and MEM is held off for that cycle.
- Undefined:
  - Strict MEM-over-ALU priority, with no counter state.
  - An ALU can wait indefinitely under continuous loads.

## Structure
- The shared header `crp16_defs.vh` holds:
  - `CRP16_REG_ZERO` (4'd0)
  - `CRP16_REG_IDX_W` (4)
  - `CRP16_WORD_W` (16)
- One natural sub-module, `crp16_wb_starve_counter`:
  - Saturating counter with inc/clear/limit-reached outputs.
  - Instantiated only under `CRP16_WB_FAIRNESS_EN`.

## Test plan
- **Reset:** hold `reset` 2 cycles with `mem_valid=1`, `mem_dest=3`. Expect no readies and `rf_write=0`. MEM is accepted on the first post-reset edge, then `rf_write=1`, select 3.
- **Simultaneous same dest:** ALU (dest 5, 0x1111) and MEM (dest 5, 0x2222) in the same cycle. Expect writes 0x2222 then 0x1111 on consecutive cycles; r5 ends at 0x1111.
- **R0 drop:** MEM dest 0, data 0xBEEF. Expect `mem_ready=1` and `rf_write=0` the next cycle.
- **Starvation (macro on, STARVE_LIMIT=3):** `mem_valid` held high 8 cycles, `alu_valid` high throughout. Expect the ALU accepted on the 4th cycle with `mem_ready=0` that cycle, and the counter cleared.
- **Starvation (macro off):** same stimulus. Expect the ALU never accepted until `mem_valid` drops, then accepted that cycle.
- **Back-to-back stream:** alternate single-producer valids for 10 cycles. Expect `rf_write=1` on every cycle from 1 to 10, with select/data matching in order.
